// File: rtl/cep_pkg.sv
// cep_pkg: shared sizes and FSM state encoding for the cepstral feature store writer.
package cep_pkg;
  localparam int N_COEF     = 26;
  localparam int MAX_FRAMES = 256;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 16;
  localparam int FC_W       = 9;
  localparam int CI_W       = 5;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/cep_addr_gen.sv
// cep_addr_gen: frame-major address counters; base advances by N_COEF per frame via an adder.
module cep_addr_gen
  import cep_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [CI_W-1:0]   o_coef_idx,
  output logic [FC_W-1:0]   o_frame_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap,
  output logic              o_full
);
  logic [CI_W-1:0]   r_ci;
  logic [FC_W-1:0]   r_fi;
  logic [ADDR_W-1:0] r_base;
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_ci   <= '0;
      r_fi   <= '0;
      r_base <= '0;
    end else if (i_adv) begin
      r_ci   <= o_wrap ? '0 : r_ci + 1'b1;
      r_fi   <= o_wrap ? r_fi + 1'b1 : r_fi;
      r_base <= o_wrap ? r_base + ADDR_W'(N_COEF) : r_base;
    end
  end
  assign o_coef_idx  = r_ci;
  assign o_frame_idx = r_fi;
  assign o_addr      = r_base + ADDR_W'(r_ci);
  assign o_wrap      = r_ci == CI_W'(N_COEF - 1);
  assign o_full      = r_fi == FC_W'(MAX_FRAMES);
endmodule

// File: rtl/cep_writer.sv
// cep_writer: accepts MFCC coefficients, issues registered store write strobes,
// counts frames and reports overflow/partial on utterance close.
module cep_writer
  import cep_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic              utt_end,
  output logic [ADDR_W-1:0] regcep_addr,
  output logic [DATA_W-1:0] regcep_in,
  output logic              regcep_wren,
  output logic              busy,
  output logic              done,
  output logic [FC_W-1:0]   frame_count,
  output logic              overflow,
  output logic              partial
);
  logic [1:0]        r_state;
  logic              r_wren, r_ovf, r_part;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [FC_W-1:0]   r_fc;
  logic [CI_W-1:0]   w_ci, w_ci_next;
  logic [FC_W-1:0]   w_fi, w_fc_next;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wrap, w_full, w_hs, w_clr, w_ovf, w_close;
  cep_addr_gen u_addr (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_clr),
    .i_adv       (w_hs),
    .o_coef_idx  (w_ci),
    .o_frame_idx (w_fi),
    .o_addr      (w_addr),
    .o_wrap      (w_wrap),
    .o_full      (w_full)
  );
  assign coef_ready = r_state == WRITE && !w_full;
  assign w_hs       = coef_valid && coef_ready;
  assign w_clr      = r_state == IDLE && start;
  assign w_ovf      = w_hs && w_wrap && w_fi == FC_W'(MAX_FRAMES - 1);
  assign w_close    = r_state == WRITE && (utt_end || w_ovf);
  // close is judged on the counters as they stand after this cycle's handshake
  assign w_ci_next  = w_hs ? (w_wrap ? '0 : w_ci + 1'b1) : w_ci;
  assign w_fc_next  = w_fi + FC_W'(w_hs && w_wrap);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_fc    <= '0;
      r_ovf   <= 1'b0;
      r_part  <= 1'b0;
    end else begin
      r_wren  <= w_hs;
      r_addr  <= w_hs ? w_addr : r_addr;
      r_data  <= w_hs ? coef_in : r_data;
      r_state <= w_clr ? WRITE : w_close ? DONE : r_state == WRITE ? WRITE : IDLE;
      if (w_clr) begin
        r_fc   <= '0;
        r_ovf  <= 1'b0;
        r_part <= 1'b0;
      end else if (w_close) begin
        r_fc   <= w_fc_next;
        r_ovf  <= w_ovf;
        r_part <= w_ci_next != '0;
      end
    end
  end
  assign regcep_wren = r_wren;
  assign regcep_addr = r_addr;
  assign regcep_in   = r_data;
  assign busy        = r_state == WRITE;
  assign done        = r_state == DONE;
  assign frame_count = r_fc;
  assign overflow    = r_ovf;
  assign partial     = r_part;
endmodule

// File: tb/tb_cep_writer.sv
// tb_cep_writer: table-driven cycle vectors plus directed multi-cycle utterance scenarios.
`timescale 1ns/1ps
module tb_cep_writer;
  logic        clk = 1'b0;
  logic        reset, start, coef_valid, utt_end;
  logic [15:0] coef_in;
  logic        coef_ready, regcep_wren, busy, done, overflow, partial;
  logic [12:0] regcep_addr;
  logic [15:0] regcep_in;
  logic [8:0]  frame_count;
  int          total = 0, bad = 0;
  logic [12:0] wa[$];
  logic [15:0] wd[$];

  cep_writer dut (
    .clk(clk), .reset(reset), .start(start), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .utt_end(utt_end),
    .regcep_addr(regcep_addr), .regcep_in(regcep_in), .regcep_wren(regcep_wren),
    .busy(busy), .done(done), .frame_count(frame_count),
    .overflow(overflow), .partial(partial)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (regcep_wren) begin
      wa.push_back(regcep_addr);
      wd.push_back(regcep_in);
    end

  typedef struct {
    logic        st, v, ue;
    logic [15:0] d;
    logic [43:0] exp;
  } vec_t;
  vec_t vecs[11];

  function automatic logic [43:0] pk(logic wr, logic [12:0] a, logic [15:0] din, logic rdy,
                                     logic bz, logic dn, logic [8:0] fc, logic pt, logic ov);
    return {wr, a, din, rdy, bz, dn, fc, pt, ov};
  endfunction

  function automatic logic [43:0] outs();
    return {regcep_wren, regcep_addr, regcep_in, coef_ready, busy, done, frame_count, partial, overflow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic idle_in();
    start = 1'b0;
    coef_valid = 1'b0;
    utt_end = 1'b0;
    coef_in = '0;
  endtask

  task automatic begin_utt();
    wa.delete();
    wd.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      coef_valid = 1'b1;
      coef_in = i[15:0];
      step();
    end
    coef_valid = 1'b0;
  endtask

  task automatic close_chk(input string nm, input logic [8:0] fc, input logic pt, input logic ov);
    chk({nm, "_close"}, {done, busy, coef_ready, frame_count, partial, overflow}, {3'b100, fc, pt, ov});
    step();
    chk({nm, "_done_drop"}, {done, busy}, 2'b00);
  endtask

  task automatic check_writes(input string nm, input int n);
    int errs = 0;
    chk({nm, "_nwrites"}, wa.size(), n);
    for (int i = 0; i < wa.size() && i < n; i++)
      if (wa[i] !== i[12:0] || wd[i] !== i[15:0]) errs++;
    chk({nm, "_wdata"}, errs, 0);
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    step();
    step();
    chk("reset_state", outs(), 44'd0);
    reset = 1'b1;
    step();

    vecs[0]  = '{1, 0, 0, 16'h0000, pk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 0)};
    vecs[1]  = '{0, 1, 0, 16'hAAAA, pk(1, 0, 16'hAAAA, 1, 1, 0, 0, 0, 0)};
    vecs[2]  = '{0, 0, 0, 16'h0000, pk(0, 0, 16'hAAAA, 1, 1, 0, 0, 0, 0)};
    vecs[3]  = '{0, 1, 0, 16'h1234, pk(1, 1, 16'h1234, 1, 1, 0, 0, 0, 0)};
    vecs[4]  = '{1, 0, 0, 16'h0000, pk(0, 1, 16'h1234, 1, 1, 0, 0, 0, 0)};
    vecs[5]  = '{0, 1, 1, 16'h5555, pk(1, 2, 16'h5555, 0, 0, 1, 0, 1, 0)};
    vecs[6]  = '{0, 0, 1, 16'h0000, pk(0, 2, 16'h5555, 0, 0, 0, 0, 1, 0)};
    vecs[7]  = '{0, 1, 0, 16'h7777, pk(0, 2, 16'h5555, 0, 0, 0, 0, 1, 0)};
    vecs[8]  = '{1, 0, 0, 16'h0000, pk(0, 2, 16'h5555, 1, 1, 0, 0, 0, 0)};
    vecs[9]  = '{0, 1, 0, 16'h0001, pk(1, 0, 16'h0001, 1, 1, 0, 0, 0, 0)};
    vecs[10] = '{0, 0, 1, 16'h0000, pk(0, 0, 16'h0001, 0, 0, 1, 0, 1, 0)};
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].st;
      coef_valid = vecs[i].v;
      utt_end = vecs[i].ue;
      coef_in = vecs[i].d;
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    idle_in();
    step();

    begin_utt();
    send(52);
    utt_end = 1'b1;
    step();
    utt_end = 1'b0;
    close_chk("two_frames", 9'd2, 1'b0, 1'b0);
    check_writes("two_frames", 52);

    begin_utt();
    begin
      int k = 0;
      for (int i = 0; i < 52; i++) begin
        coef_valid = (i % 2) == 0;
        coef_in = k[15:0];
        if (coef_valid) k++;
        step();
      end
    end
    coef_valid = 1'b0;
    utt_end = 1'b1;
    step();
    utt_end = 1'b0;
    close_chk("throttled", 9'd1, 1'b0, 1'b0);
    check_writes("throttled", 26);

    begin_utt();
    send(36);
    utt_end = 1'b1;
    step();
    utt_end = 1'b0;
    close_chk("mid_frame", 9'd1, 1'b1, 1'b0);
    check_writes("mid_frame", 36);

    begin_utt();
    send(25);
    coef_valid = 1'b1;
    coef_in = 16'd25;
    utt_end = 1'b1;
    step();
    idle_in();
    chk("same_cycle_strobe", {regcep_wren, regcep_addr}, {1'b1, 13'd25});
    close_chk("same_cycle", 9'd1, 1'b0, 1'b0);
    check_writes("same_cycle", 26);

    begin_utt();
    send(6656);
    close_chk("overflow", 9'd256, 1'b0, 1'b1);
    coef_valid = 1'b1;
    repeat (4) step();
    coef_valid = 1'b0;
    step();
    check_writes("overflow", 6656);
    chk("overflow_last_addr", wa.size() > 0 ? wa[wa.size()-1] : 13'd0, 13'd6655);

    begin_utt();
    send(10);
    coef_valid = 1'b1;
    coef_in = 16'd77;
    reset = 1'b0;
    step();
    chk("reset_mid_outs", outs(), 44'd0);
    reset = 1'b1;
    coef_valid = 1'b0;
    step();
    chk("reset_mid_nwrites", wa.size(), 10);
    chk("reset_mid_idle", {busy, coef_ready, regcep_wren}, 3'b000);
    begin_utt();
    coef_valid = 1'b1;
    coef_in = 16'h0BAD;
    step();
    coef_valid = 1'b0;
    chk("restart_write", {regcep_wren, regcep_addr, regcep_in}, {1'b1, 13'd0, 16'h0BAD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
